// File: rtl/prio_index_decoder.sv
// Index-to-one-hot decoder with valid/ready intake, fixed-width pulses and a guard gap.
// Out-of-range indices are absorbed with a one-cycle err pulse; good ones are counted.
module prio_index_decoder #(
    parameter int IDX_W     = 2,
    parameter int N_OUT     = 4,
    parameter int PULSE_LEN = 3,
    parameter int GAP_LEN   = 1,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [IDX_W-1:0] in_idx,
    output logic             in_ready,
    output logic [N_OUT-1:0] out_onehot,
    output logic             out_active,
    output logic             err,
    output logic [IDX_W-1:0] last_idx,
    output logic [CNT_W-1:0] disp_cnt
);

    // Handshake: a transfer happens on a rising edge where in_valid && in_ready;
    // in_ready is a pure decode of state, so it never depends on in_valid.

    localparam int TMAX    = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
    localparam int TIMER_W = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [TIMER_W-1:0] PULSE_LOAD = TIMER_W'(PULSE_LEN - 1);
    localparam logic [TIMER_W-1:0] GAP_LOAD   = TIMER_W'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);
    localparam logic [IDX_W:0]     N_OUT_LIM  = (IDX_W + 1)'(N_OUT);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_GAP    = 2'd2
    } state_t;

    state_t             state, state_nx;
    logic [TIMER_W-1:0] timer, timer_nx;
    logic [N_OUT-1:0]   onehot_nx;
    logic               active_nx;
    logic               err_nx;
    logic [IDX_W-1:0]   last_nx;
    logic [CNT_W-1:0]   cnt_nx;
    logic               accept;
    logic               in_range;

    assign in_ready = (state == S_IDLE);
    assign accept   = in_valid && in_ready;
    assign in_range = ({1'b0, in_idx} < N_OUT_LIM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            timer      <= '0;
            out_onehot <= '0;
            out_active <= 1'b0;
            err        <= 1'b0;
            last_idx   <= '0;
            disp_cnt   <= '0;
        end else begin
            state      <= state_nx;
            timer      <= timer_nx;
            out_onehot <= onehot_nx;
            out_active <= active_nx;
            err        <= err_nx;
            last_idx   <= last_nx;
            disp_cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        timer_nx  = timer;
        onehot_nx = out_onehot;
        active_nx = out_active;
        err_nx    = 1'b0;
        last_nx   = last_idx;
        cnt_nx    = disp_cnt;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (in_range) begin
                        state_nx  = S_ACTIVE;
                        timer_nx  = PULSE_LOAD;
                        onehot_nx = N_OUT'(1) << in_idx;
                        active_nx = 1'b1;
                        last_nx   = in_idx;
                        cnt_nx    = disp_cnt + CNT_W'(1);
                    end else begin
                        err_nx = 1'b1;
                    end
                end
            end
            S_ACTIVE: begin
                if (timer != '0) begin
                    timer_nx = timer - TIMER_W'(1);
                end else begin
                    onehot_nx = '0;
                    active_nx = 1'b0;
                    // A zero-length gap returns straight to IDLE.
                    if (GAP_LEN > 0) begin
                        state_nx = S_GAP;
                        timer_nx = GAP_LOAD;
                    end else begin
                        state_nx = S_IDLE;
                    end
                end
            end
            S_GAP: begin
                if (timer != '0) begin
                    timer_nx = timer - TIMER_W'(1);
                end else begin
                    state_nx = S_IDLE;
                end
            end
            default: begin
                state_nx  = S_IDLE;
                onehot_nx = '0;
                active_nx = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_prio_index_decoder.sv
// Bench for prio_index_decoder: two instances (default and N_OUT=3/CNT_W=2/PULSE_LEN=1/GAP_LEN=0)
// driven by vector tables, directed sequences and random traffic against a timing model.
module tb_prio_index_decoder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       v0, r0, a0, e0;
    logic [1:0] i0, l0;
    logic [3:0] oh0;
    logic [7:0] c0;

    logic       v1, r1, a1, e1;
    logic [1:0] i1, l1, c1;
    logic [2:0] oh1;

    prio_index_decoder #(.IDX_W(2), .N_OUT(4), .PULSE_LEN(3), .GAP_LEN(1), .CNT_W(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(v0), .in_idx(i0), .in_ready(r0),
        .out_onehot(oh0), .out_active(a0), .err(e0), .last_idx(l0), .disp_cnt(c0)
    );

    prio_index_decoder #(.IDX_W(2), .N_OUT(3), .PULSE_LEN(1), .GAP_LEN(0), .CNT_W(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_idx(i1), .in_ready(r1),
        .out_onehot(oh1), .out_active(a1), .err(e1), .last_idx(l1), .disp_cnt(c1)
    );

    int checks = 0;
    int errors = 0;
    int e = 0;

    // Model: remembers only when the last good accept and the last bad accept happened.
    typedef struct {
        int k;
        int err_e;
        int idx;
        int cnt;
    } mdl_t;

    localparam mdl_t MDL_RST = '{-100000, -1, 0, 0};
    mdl_t m0 = MDL_RST;
    mdl_t m1 = MDL_RST;

    typedef struct {
        logic       v;
        logic [1:0] idx;
        logic [3:0] oh;
        logic       rdy;
        logic       er;
        logic [1:0] last;
        logic [7:0] cnt;
    } vec_t;

    vec_t t0[12];
    vec_t t1[12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", nm, e, act, exp);
        end
    endtask

    function automatic mdl_t mdl_edge(input mdl_t m, input logic v, input int idx,
                                      input int n, input int p, input int g, input int cmax);
        mdl_t r = m;
        if (v && (e - 1 >= m.k + p + g)) begin
            if (idx < n) begin
                r.k   = e;
                r.idx = idx;
                r.cnt = (m.cnt + 1) % cmax;
            end else begin
                r.err_e = e;
            end
        end
        return r;
    endfunction

    task automatic chk_mdl(input string tag, input mdl_t m, input int p, input int g,
                           input logic [3:0] oh, input logic rdy, input logic act,
                           input logic er, input logic [1:0] last, input logic [7:0] cnt);
        logic [3:0] exp_oh;
        exp_oh = (e >= m.k && e <= m.k + p - 1) ? 4'(1 << m.idx) : 4'd0;
        chk({tag, "_onehot"}, 32'(oh), 32'(exp_oh));
        chk({tag, "_active"}, 32'(act), 32'(exp_oh != 4'd0));
        chk({tag, "_ready"}, 32'(rdy), 32'(e >= m.k + p + g));
        chk({tag, "_err"}, 32'(er), 32'(e == m.err_e));
        chk({tag, "_last"}, 32'(last), 32'(m.idx));
        chk({tag, "_cnt"}, 32'(cnt), 32'(m.cnt));
    endtask

    // One clock: model advances at the rising edge, DUT outputs compared on the falling edge.
    task automatic step();
        @(posedge clk);
        e++;
        m0 = mdl_edge(m0, v0, int'(i0), 4, 3, 1, 256);
        m1 = mdl_edge(m1, v1, int'(i1), 3, 1, 0, 4);
        @(negedge clk);
        chk_mdl("d0", m0, 3, 1, oh0, r0, a0, e0, l0, c0);
        chk_mdl("d1", m1, 1, 0, {1'b0, oh1}, r1, a1, e1, l1, {6'd0, c1});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int waited;
        v0 = 1'b0; i0 = 2'd0; v1 = 1'b0; i1 = 2'd0;

        // Default instance: accept idx 2, ignore changes while busy, then accept idx 0 and 1.
        t0[0]  = '{1'b1, 2'd2, 4'b0100, 1'b0, 1'b0, 2'd2, 8'd1};
        t0[1]  = '{1'b1, 2'd1, 4'b0100, 1'b0, 1'b0, 2'd2, 8'd1};
        t0[2]  = '{1'b1, 2'd3, 4'b0100, 1'b0, 1'b0, 2'd2, 8'd1};
        t0[3]  = '{1'b0, 2'd0, 4'b0000, 1'b0, 1'b0, 2'd2, 8'd1};
        t0[4]  = '{1'b1, 2'd1, 4'b0000, 1'b1, 1'b0, 2'd2, 8'd1};
        t0[5]  = '{1'b1, 2'd0, 4'b0001, 1'b0, 1'b0, 2'd0, 8'd2};
        t0[6]  = '{1'b1, 2'd1, 4'b0001, 1'b0, 1'b0, 2'd0, 8'd2};
        t0[7]  = '{1'b1, 2'd1, 4'b0001, 1'b0, 1'b0, 2'd0, 8'd2};
        t0[8]  = '{1'b1, 2'd1, 4'b0000, 1'b0, 1'b0, 2'd0, 8'd2};
        t0[9]  = '{1'b1, 2'd1, 4'b0000, 1'b1, 1'b0, 2'd0, 8'd2};
        t0[10] = '{1'b1, 2'd1, 4'b0010, 1'b0, 1'b0, 2'd1, 8'd3};
        t0[11] = '{1'b0, 2'd0, 4'b0010, 1'b0, 1'b0, 2'd1, 8'd3};
        // Small instance: out-of-range err, then back-to-back accepts wrapping the 2-bit count.
        t1[0]  = '{1'b1, 2'd3, 4'b0000, 1'b1, 1'b1, 2'd0, 8'd0};
        t1[1]  = '{1'b0, 2'd0, 4'b0000, 1'b1, 1'b0, 2'd0, 8'd0};
        t1[2]  = '{1'b1, 2'd0, 4'b0001, 1'b0, 1'b0, 2'd0, 8'd1};
        t1[3]  = '{1'b1, 2'd0, 4'b0000, 1'b1, 1'b0, 2'd0, 8'd1};
        t1[4]  = '{1'b1, 2'd1, 4'b0010, 1'b0, 1'b0, 2'd1, 8'd2};
        t1[5]  = '{1'b1, 2'd1, 4'b0000, 1'b1, 1'b0, 2'd1, 8'd2};
        t1[6]  = '{1'b1, 2'd2, 4'b0100, 1'b0, 1'b0, 2'd2, 8'd3};
        t1[7]  = '{1'b1, 2'd2, 4'b0000, 1'b1, 1'b0, 2'd2, 8'd3};
        t1[8]  = '{1'b1, 2'd0, 4'b0001, 1'b0, 1'b0, 2'd0, 8'd0};
        t1[9]  = '{1'b1, 2'd0, 4'b0000, 1'b1, 1'b0, 2'd0, 8'd0};
        t1[10] = '{1'b1, 2'd1, 4'b0010, 1'b0, 1'b0, 2'd1, 8'd1};
        t1[11] = '{1'b0, 2'd0, 4'b0000, 1'b1, 1'b0, 2'd1, 8'd1};

        // Reset values while rst_n is held low.
        repeat (3) @(negedge clk);
        chk("rst_onehot0", 32'(oh0), 32'd0);
        chk("rst_active0", 32'(a0), 32'd0);
        chk("rst_ready0", 32'(r0), 32'd1);
        chk("rst_err0", 32'(e0), 32'd0);
        chk("rst_last0", 32'(l0), 32'd0);
        chk("rst_cnt0", 32'(c0), 32'd0);
        chk("rst_ready1", 32'(r1), 32'd1);
        chk("rst_cnt1", 32'(c1), 32'd0);
        rst_n = 1'b1;
        e = 0;

        for (int i = 0; i < 12; i++) begin
            v0 = t0[i].v; i0 = t0[i].idx;
            v1 = t1[i].v; i1 = t1[i].idx;
            step();
            chk($sformatf("tab0_%0d_onehot", i), 32'(oh0), 32'(t0[i].oh));
            chk($sformatf("tab0_%0d_active", i), 32'(a0), 32'(t0[i].oh != 4'd0));
            chk($sformatf("tab0_%0d_ready", i), 32'(r0), 32'(t0[i].rdy));
            chk($sformatf("tab0_%0d_err", i), 32'(e0), 32'(t0[i].er));
            chk($sformatf("tab0_%0d_last", i), 32'(l0), 32'(t0[i].last));
            chk($sformatf("tab0_%0d_cnt", i), 32'(c0), 32'(t0[i].cnt));
            chk($sformatf("tab1_%0d_onehot", i), 32'(oh1), 32'(t1[i].oh));
            chk($sformatf("tab1_%0d_ready", i), 32'(r1), 32'(t1[i].rdy));
            chk($sformatf("tab1_%0d_err", i), 32'(e1), 32'(t1[i].er));
            chk($sformatf("tab1_%0d_last", i), 32'(l1), 32'(t1[i].last));
            chk($sformatf("tab1_%0d_cnt", i), 32'(c1), 32'(t1[i].cnt));
        end

        for (int i = 0; i < 400; i++) begin
            v0 = ($urandom_range(0, 3) != 0);
            i0 = 2'($urandom_range(0, 3));
            v1 = ($urandom_range(0, 3) != 0);
            i1 = 2'($urandom_range(0, 3));
            step();
        end

        // Reset pulled low on the second pulse cycle clears everything without a clock edge.
        v0 = 1'b0; v1 = 1'b0;
        repeat (6) step();
        v0 = 1'b1; i0 = 2'd3;
        step();
        v0 = 1'b0;
        step();
        chk("pre_rst_onehot", 32'(oh0), 32'h8);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_onehot", 32'(oh0), 32'd0);
        chk("async_rst_active", 32'(a0), 32'd0);
        chk("async_rst_cnt", 32'(c0), 32'd0);
        chk("async_rst_ready", 32'(r0), 32'd1);
        chk("async_rst_last", 32'(l0), 32'd0);
        #1 rst_n = 1'b1;
        m0 = MDL_RST;
        m1 = MDL_RST;

        // Sweep every index, each held until taken.
        for (int idx = 0; idx < 4; idx++) begin
            v0 = 1'b1; i0 = 2'(idx);
            waited = 0;
            do begin
                step();
                waited++;
            end while (m0.k != e && waited < 10);
            chk($sformatf("sweep_accept_%0d", idx), 32'(oh0), 32'(1 << idx));
        end
        v0 = 1'b0;
        repeat (5) step();
        chk("sweep_final_cnt", 32'(c0), 32'd4);

        for (int i = 0; i < 40; i++) begin
            v0 = ($urandom_range(0, 1) != 0);
            i0 = 2'($urandom_range(0, 3));
            v1 = ($urandom_range(0, 1) != 0);
            i1 = 2'($urandom_range(0, 3));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
